// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified I/D memory port, data over fetch,
// and runs each access for LAT cycles before a one-cycle ack.
module mem_port_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_wr_n,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_wr_n,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_wr_n_q, mem_wr_n_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;

  // A requester still holding req in its ack cycle is already served.
  logic d_go;
  logic if_go;
  assign d_go  = d_req & ~d_ack_q;
  assign if_go = if_req & ~if_ack_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_wr_n_d  = mem_wr_n_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_en_d   = 1'b0;
        mem_wr_n_d = 1'b1;
        if (d_go) begin
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wr_n_d  = d_wr_n;
          owner_d     = 1'b1;
          mem_en_d    = 1'b1;
          cnt_d       = CNT_LAST;
          state_d     = BUSY;
        end else if (if_go) begin
          mem_addr_d = if_addr;
          mem_wr_n_d = 1'b1;
          owner_d    = 1'b0;
          mem_en_d   = 1'b1;
          cnt_d      = CNT_LAST;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!owner_q) begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end else begin
            if (mem_wr_n_q) d_rdata_d = mem_rdata;
            d_ack_d = 1'b1;
          end
          mem_en_d   = 1'b0;
          mem_wr_n_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_n_q  <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_wr_n_q  <= mem_wr_n_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_wr_n  = mem_wr_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == BUSY);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a random request stream
// checked against a transaction-level schedule and reference memory.
module tb_mem_port_arbiter;
  parameter int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_wr_n;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_wr_n;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        owner;

  int checks = 0;
  int errs   = 0;
  logic [15:0] exp_ird, exp_drd;

  mem_port_arbiter #(.AW(16), .DW(16), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_wr_n(d_wr_n),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_wr_n(mem_wr_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seed(input logic [15:0] a);
    return a ^ 16'h1224;
  endfunction

  // Memory device: data valid only in the last enabled cycle.
  logic [15:0] env_mem [0:1023];
  bit          env_wr  [0:1023];
  int          en_run;
  logic [15:0] env_v;

  always @(posedge clk) begin
    if (rst || !mem_en) en_run <= 0;
    else en_run <= en_run + 1;
    if (!rst && mem_en && !mem_wr_n && en_run == LAT - 1) begin
      env_mem[mem_addr[9:0]] <= mem_wdata;
      env_wr[mem_addr[9:0]]  <= 1'b1;
    end
  end

  always_comb begin
    env_v = env_wr[mem_addr[9:0]] ? env_mem[mem_addr[9:0]] : seed(mem_addr);
    mem_rdata = (mem_en && en_run == LAT - 1) ? env_v : ~env_v;
  end

  // Reference memory contents as the requesters see them.
  logic [15:0] ref_mem [0:1023];
  bit          ref_wr  [0:1023];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr[a[9:0]] ? ref_mem[a[9:0]] : seed(a);
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a[9:0]] = d;
    ref_wr[a[9:0]]  = 1'b1;
  endtask

  task automatic run_one(
    input  bit is_d, input bit wr_n,
    input  logic [15:0] a, input logic [15:0] wd,
    output int en_n, output int ack_at,
    output int ack_n, output int oth_n,
    output logic [15:0] a_s, output logic w_s,
    output logic [15:0] wd_s, output bit stable,
    output logic [15:0] rd
  );
    en_n = 0; ack_at = -1; ack_n = 0; oth_n = 0;
    a_s = '0; w_s = 1'b1; wd_s = '0; stable = 1'b1; rd = '0;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_wr_n = wr_n; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    for (int k = 1; k <= 2 * LAT + 4; k++) begin
      @(negedge clk);
      if (ack_at > 0 && k == ack_at + 1) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      if (mem_en) begin
        if (en_n == 0) begin
          a_s = mem_addr; w_s = mem_wr_n; wd_s = mem_wdata;
        end else if (mem_addr !== a_s || mem_wr_n !== w_s
                     || mem_wdata !== wd_s) begin
          stable = 1'b0;
        end
        en_n++;
      end
      if ((is_d ? d_ack : if_ack) === 1'b1) begin
        ack_n++;
        if (ack_at < 0) begin
          ack_at = k;
          rd = is_d ? d_rdata : if_rdata;
        end
      end
      if ((is_d ? if_ack : d_ack) === 1'b1) oth_n++;
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_wr_n = 1'b1; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errs++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    checks++; if (mem_wr_n !== 1'b1) begin errs++; $display("FAIL reset_mem_wr_n got %b want 1", mem_wr_n); end
    checks++; if (mem_addr !== 16'h0) begin errs++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin errs++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (if_rdata !== 16'h0) begin errs++; $display("FAIL reset_if_rdata got %h want 0", if_rdata); end
    checks++; if (d_rdata !== 16'h0) begin errs++; $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
    checks++; if (if_ack !== 1'b0) begin errs++; $display("FAIL reset_if_ack got %b want 0", if_ack); end
    checks++; if (d_ack !== 1'b0) begin errs++; $display("FAIL reset_d_ack got %b want 0", d_ack); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (owner !== 1'b0) begin errs++; $display("FAIL reset_owner got %b want 0", owner); end
    rst = 1'b0;
    exp_ird = '0; exp_drd = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_store();
    int en_n, ack_at, ack_n, oth_n;
    logic [15:0] a_s, wd_s, rd;
    logic w_s;
    bit stable;
    run_one(1'b1, 1'b0, 16'h0100, 16'hBEEF,
            en_n, ack_at, ack_n, oth_n, a_s, w_s, wd_s, stable, rd);
    ref_write(16'h0100, 16'hBEEF);
    checks++; if (en_n != LAT) begin errs++; $display("FAIL store_en_width got %0d want %0d", en_n, LAT); end
    checks++; if (w_s !== 1'b0) begin errs++; $display("FAIL store_wr_n got %b want 0", w_s); end
    checks++; if (a_s !== 16'h0100) begin errs++; $display("FAIL store_addr got %h want 0100", a_s); end
    checks++; if (wd_s !== 16'hBEEF) begin errs++; $display("FAIL store_wdata got %h want beef", wd_s); end
    checks++; if (!stable) begin errs++; $display("FAIL store_stable got 0 want 1"); end
    checks++; if (ack_at != LAT + 1) begin errs++; $display("FAIL store_latency got %0d want %0d", ack_at, LAT + 1); end
    checks++; if (ack_n != 1 || oth_n != 0) begin errs++; $display("FAIL store_acks got %0d/%0d want 1/0", ack_n, oth_n); end
    checks++; if (d_rdata !== exp_drd) begin errs++; $display("FAIL store_d_rdata got %h want %h", d_rdata, exp_drd); end
    checks++; if (owner !== 1'b1) begin errs++; $display("FAIL store_owner got %b want 1", owner); end
  endtask

  task automatic test_single_fetch();
    int en_n, ack_at, ack_n, oth_n;
    logic [15:0] a_s, wd_s, rd, exp;
    logic w_s;
    bit stable;
    exp = ref_rd(16'h0010);
    run_one(1'b0, 1'b1, 16'h0010, 16'h0,
            en_n, ack_at, ack_n, oth_n, a_s, w_s, wd_s, stable, rd);
    exp_ird = exp;
    checks++; if (exp !== 16'h1234) begin errs++; $display("FAIL fetch_seed got %h want 1234", exp); end
    checks++; if (en_n != LAT) begin errs++; $display("FAIL fetch_en_width got %0d want %0d", en_n, LAT); end
    checks++; if (a_s !== 16'h0010 || w_s !== 1'b1) begin errs++; $display("FAIL fetch_addr got %h/%b want 0010/1", a_s, w_s); end
    checks++; if (!stable) begin errs++; $display("FAIL fetch_stable got 0 want 1"); end
    checks++; if (ack_at != LAT + 1) begin errs++; $display("FAIL fetch_latency got %0d want %0d", ack_at, LAT + 1); end
    checks++; if (rd !== exp) begin errs++; $display("FAIL fetch_rdata got %h want %h", rd, exp); end
    checks++; if (ack_n != 1 || oth_n != 0) begin errs++; $display("FAIL held_mask_acks got %0d/%0d want 1/0", ack_n, oth_n); end
    checks++; if (if_rdata !== exp) begin errs++; $display("FAIL fetch_rdata_hold got %h want %h", if_rdata, exp); end
    checks++; if (owner !== 1'b0) begin errs++; $display("FAIL fetch_owner got %b want 0", owner); end
  endtask

  task automatic test_load_after_store();
    int en_n, ack_at, ack_n, oth_n;
    logic [15:0] a_s, wd_s, rd;
    logic w_s;
    bit stable;
    run_one(1'b1, 1'b1, 16'h0100, 16'h5555,
            en_n, ack_at, ack_n, oth_n, a_s, w_s, wd_s, stable, rd);
    exp_drd = ref_rd(16'h0100);
    checks++; if (rd !== exp_drd) begin errs++; $display("FAIL load_rdata got %h want %h", rd, exp_drd); end
    checks++; if (w_s !== 1'b1) begin errs++; $display("FAIL load_wr_n got %b want 1", w_s); end
    checks++; if (ack_at != LAT + 1) begin errs++; $display("FAIL load_latency got %0d want %0d", ack_at, LAT + 1); end
  endtask

  task automatic test_collision();
    int da, ia, both, en_n, dn, in_n;
    logic o1, o2;
    logic [15:0] drd, ird, de, ie;
    de = ref_rd(16'h0200); ie = ref_rd(16'h0020);
    da = -1; ia = -1; both = 0; en_n = 0; dn = 0; in_n = 0;
    o1 = 1'b0; o2 = 1'b1; drd = '0; ird = '0;
    @(negedge clk);
    d_req = 1'b1; d_wr_n = 1'b1; d_addr = 16'h0200;
    if_req = 1'b1; if_addr = 16'h0020;
    for (int k = 1; k <= 3 * LAT + 6; k++) begin
      @(negedge clk);
      if (da > 0 && k == da + 1) d_req = 1'b0;
      if (ia > 0 && k == ia + 1) if_req = 1'b0;
      if (mem_en) en_n++;
      if (k == 1) o1 = owner;
      if (k == LAT + 2) o2 = owner;
      if (d_ack && if_ack) both++;
      if (d_ack) begin
        dn++;
        if (da < 0) begin da = k; drd = d_rdata; end
      end
      if (if_ack) begin
        in_n++;
        if (ia < 0) begin ia = k; ird = if_rdata; end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    exp_drd = de; exp_ird = ie;
    checks++; if (da != LAT + 1) begin errs++; $display("FAIL coll_d_ack_at got %0d want %0d", da, LAT + 1); end
    checks++; if (ia != 2 * LAT + 2) begin errs++; $display("FAIL coll_if_ack_at got %0d want %0d", ia, 2 * LAT + 2); end
    checks++; if (both != 0) begin errs++; $display("FAIL coll_both_acks got %0d want 0", both); end
    checks++; if (dn != 1 || in_n != 1) begin errs++; $display("FAIL coll_ack_counts got %0d/%0d want 1/1", dn, in_n); end
    checks++; if (en_n != 2 * LAT) begin errs++; $display("FAIL coll_en_cycles got %0d want %0d", en_n, 2 * LAT); end
    checks++; if (drd !== de) begin errs++; $display("FAIL coll_d_rdata got %h want %h", drd, de); end
    checks++; if (ird !== ie) begin errs++; $display("FAIL coll_if_rdata got %h want %h", ird, ie); end
    checks++; if (o1 !== 1'b1 || o2 !== 1'b0) begin errs++; $display("FAIL coll_owner got %b%b want 10", o1, o2); end
  endtask

  task automatic test_reset_abort();
    int dn, en_n, ack_at, ack_n, oth_n;
    logic b1, w_s;
    logic [15:0] a_s, wd_s, rd, exp;
    bit stable;
    @(negedge clk);
    d_req = 1'b1; d_wr_n = 1'b1; d_addr = 16'h0033;
    @(negedge clk);
    b1 = busy;
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    checks++; if (b1 !== 1'b1) begin errs++; $display("FAIL abort_busy_before got %b want 1", b1); end
    checks++; if (mem_en !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL abort_en_busy got %b%b want 00", mem_en, busy); end
    checks++; if (d_ack !== 1'b0) begin errs++; $display("FAIL abort_d_ack got %b want 0", d_ack); end
    checks++; if (mem_addr !== 16'h0 || mem_wr_n !== 1'b1 || owner !== 1'b0) begin
      errs++; $display("FAIL abort_outputs got %h/%b/%b want 0000/1/0", mem_addr, mem_wr_n, owner);
    end
    checks++; if (d_rdata !== 16'h0 || if_rdata !== 16'h0) begin
      errs++; $display("FAIL abort_rdata got %h/%h want 0/0", d_rdata, if_rdata);
    end
    rst = 1'b0;
    exp_drd = '0; exp_ird = '0;
    dn = 0; en_n = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (d_ack) dn++;
      if (mem_en) en_n++;
    end
    checks++; if (dn != 0 || en_n != 0) begin errs++; $display("FAIL abort_quiet got %0d/%0d want 0/0", dn, en_n); end
    exp = ref_rd(16'h0033);
    run_one(1'b1, 1'b1, 16'h0033, 16'h0,
            en_n, ack_at, ack_n, oth_n, a_s, w_s, wd_s, stable, rd);
    exp_drd = exp;
    checks++; if (ack_at != LAT + 1) begin errs++; $display("FAIL abort_fresh_latency got %0d want %0d", ack_at, LAT + 1); end
    checks++; if (rd !== exp || en_n != LAT) begin errs++; $display("FAIL abort_fresh got %h/%0d want %h/%0d", rd, en_n, exp, LAT); end
  endtask

  // Transaction-level schedule: a grant at cycle g owns the port for
  // g+1..g+LAT, acks at g+LAT+1, and the next grant may come at g+LAT+1.
  task automatic test_random();
    int g, nxt;
    bit gv, g_d, g_w, en_e, ia_e, da_e;
    logic [15:0] g_a, g_wd, g_rd, e_ird, e_drd;
    bit i_act, i_rel, i_pend, d_act, d_rel, d_pend;
    gv = 1'b0; nxt = 0; g = 0; g_d = 1'b0; g_w = 1'b1;
    g_a = '0; g_wd = '0; g_rd = '0;
    e_ird = exp_ird; e_drd = exp_drd;
    i_act = 0; i_rel = 0; i_pend = 0;
    d_act = 0; d_rel = 0; d_pend = 0;
    for (int c = 0; c < 120 * (LAT + 1); c++) begin
      @(negedge clk);
      en_e = gv && c > g && c <= g + LAT;
      ia_e = gv && !g_d && c == g + LAT + 1;
      da_e = gv && g_d && c == g + LAT + 1;
      if (ia_e) e_ird = g_rd;
      if (da_e && g_w) e_drd = g_rd;
      checks++; if (mem_en !== en_e) begin errs++; $display("FAIL rnd_mem_en c=%0d got %b want %b", c, mem_en, en_e); end
      checks++; if (busy !== en_e) begin errs++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, en_e); end
      checks++; if (if_ack !== ia_e) begin errs++; $display("FAIL rnd_if_ack c=%0d got %b want %b", c, if_ack, ia_e); end
      checks++; if (d_ack !== da_e) begin errs++; $display("FAIL rnd_d_ack c=%0d got %b want %b", c, d_ack, da_e); end
      checks++; if (if_rdata !== e_ird) begin errs++; $display("FAIL rnd_if_rdata c=%0d got %h want %h", c, if_rdata, e_ird); end
      checks++; if (d_rdata !== e_drd) begin errs++; $display("FAIL rnd_d_rdata c=%0d got %h want %h", c, d_rdata, e_drd); end
      if (en_e) begin
        checks++;
        if (mem_addr !== g_a || mem_wr_n !== g_w || (!g_w && mem_wdata !== g_wd)) begin
          errs++;
          $display("FAIL rnd_port c=%0d got %h/%b/%h want %h/%b/%h",
                   c, mem_addr, mem_wr_n, mem_wdata, g_a, g_w, g_wd);
        end
      end else begin
        checks++; if (mem_wr_n !== 1'b1) begin errs++; $display("FAIL rnd_idle_wr_n c=%0d got %b want 1", c, mem_wr_n); end
      end
      if (gv) begin
        checks++; if (owner !== g_d) begin errs++; $display("FAIL rnd_owner c=%0d got %b want %b", c, owner, g_d); end
      end
      if (i_rel) begin if_req = 1'b0; i_act = 0; i_rel = 0; end
      else if (i_act && if_ack === 1'b1) i_rel = 1;
      if (d_rel) begin d_req = 1'b0; d_act = 0; d_rel = 0; end
      else if (d_act && d_ack === 1'b1) d_rel = 1;
      if (!i_act && $urandom_range(0, 3) != 0) begin
        if_req = 1'b1; if_addr = 16'($urandom_range(0, 31));
        i_act = 1; i_pend = 1;
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_wr_n = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 31)); d_wdata = 16'($urandom);
        d_act = 1; d_pend = 1;
      end
      if (c >= nxt && (d_pend || i_pend)) begin
        gv = 1'b1; g = c; nxt = c + LAT + 1;
        if (d_pend) begin
          g_d = 1'b1; g_w = d_wr_n; g_a = d_addr; g_wd = d_wdata;
          if (!g_w) ref_write(g_a, g_wd);
          else g_rd = ref_rd(g_a);
          d_pend = 0;
        end else begin
          g_d = 1'b0; g_w = 1'b1; g_a = if_addr;
          g_rd = ref_rd(g_a);
          i_pend = 0;
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store();
    test_single_fetch();
    test_load_after_store();
    test_collision();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single-port unified instruction/data memory of the 16-bit pipelined core. Two requesters share the port: the fetch stage and the memory stage (LW/SW, driven from the decoder's MemEnab/MemWrite). The block grants the port with fixed data-over-fetch priority. It holds address, data and enable stable for a fixed multi-cycle access, then returns read data with a one-cycle acknowledge. The pipeline stalls on the un-acked request.

## Interface
- AW, 16, address width
- DW, 16, data width (equals ISIZE)
- LAT, 2, memory access cycles per transaction; legal range 1..16
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; level, held until if_ack seen
- if_addr  in  AW  fetch address (PC)
- if_rdata  out  DW  fetched instruction; valid while if_ack=1, held afterwards
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request (MemEnab); level, held until d_ack seen
- d_wr_n  in  1  0 = store, 1 = load (MemWrite polarity)
- d_addr  in  AW  data address (ALU result)
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid while d_ack=1, held afterwards
- d_ack  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory enable, high for exactly LAT cycles per transaction
- mem_wr_n  out  1  memory write strobe, active-low
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in last cycle of mem_en
- busy  out  1  high while state is BUSY
- owner  out  1  0 = fetch, 1 = data; owner of current or last transaction

## Operation
- States: IDLE, BUSY. 4-bit down-counter cnt, owner register.
- IDLE arbitration uses masked requests. A requester whose ack is high in the current cycle is masked.
  - d_req (masked) high: grant data. Latch d_addr, d_wdata and d_wr_n into mem_addr, mem_wdata and mem_wr_n. Set owner=1.
  - Else if_req (masked) high: grant fetch. Latch if_addr into mem_addr, set mem_wr_n=1, set owner=0.
  - On grant: mem_en<=1, cnt<=LAT-1, state<=BUSY.
  - No request: remain IDLE. mem_en=0 and mem_wr_n=1; mem_addr and mem_wdata hold.
- BUSY with cnt≠0: cnt decrements. All mem_* outputs are held stable. Request inputs are ignored and may change.
- BUSY with cnt=0 (last access cycle):
  - Capture mem_rdata into if_rdata (owner=0) or d_rdata (owner=1, load).
  - Pulse the owner's ack next cycle.
  - mem_en<=0, mem_wr_n<=1, state<=IDLE.
  - A store acks without changing d_rdata.
- Acks are registered. Each is high for exactly one cycle, and never both in the same cycle.
- Fetch starvation is permitted by design; the pipeline bounds consecutive data requests.

## Timing
- Request sampled in IDLE cycle t. BUSY occupies cycles t+1..t+LAT with mem_en high. Ack is high in cycle t+LAT+1.
- Request-to-ack latency is LAT+1 cycles.
- Back-to-back: arbitration occurs in the ack cycle, so the next BUSY starts at t+LAT+2. Throughput is one access per LAT+1 cycles.
- Simultaneous d_req and if_req in IDLE: data first, fetch granted in d_ack's cycle.
- Requester protocol: hold req and its address/data until the ack cycle. Deassert or change on the following edge.
- LAT=1: mem_en high for exactly one cycle.
- Reset values: state=IDLE, cnt=0, owner=0, mem_en=0, mem_wr_n=1, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_ack=0, d_ack=0, busy=0.
- Reset mid-BUSY: the transaction is aborted. All outputs take reset values at the next edge and no ack is issued. A store may or may not have committed.

## Test plan
- Single fetch, LAT=2: if_req=1, if_addr=0x0010, mem returns 0x1234 → mem_en high 2 cycles with mem_addr=0x0010 and mem_wr_n=1; if_ack in cycle 3 with if_rdata=0x1234.
- Store: d_req=1, d_wr_n=0, d_addr=0x0100, d_wdata=0xBEEF → mem_wr_n=0 and mem_wdata=0xBEEF for 2 cycles; d_ack after; d_rdata unchanged (0x0000 after reset).
- Collision: if_req and d_req (load 0x0200) rise together → data served first, d_ack at cycle 3; fetch granted in same cycle, if_ack at cycle 6; never both acks high.
- Held request masking: requester keeps if_req high one cycle past if_ack → exactly one fetch transaction per request, no duplicate mem_en burst.
- Reset at BUSY cycle 1 of a load → next cycle mem_en=0, busy=0, no d_ack; fresh request afterwards completes with normal LAT+1 latency.
- LAT=1 and LAT=16 builds: alternating fetch/load stream → mem_en width equals LAT, ack spacing LAT+1, counter never wraps.
